ram_sync_clr: RTL and testbench
===============================

RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 SHALL have parameter DW, default 16, data word width in bits.
REQ-002 SHALL have parameter AW, default 14, address width; depth = 2**AW words (16384 at default).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  access enable; r and w are ignored when low.
REQ-006 SHALL have port w  input  1  write request; takes priority over r.
REQ-007 SHALL have port r  input  1  read request.
REQ-008 SHALL have port add  input  AW  word address.
REQ-009 SHALL have port d_in  input  DW  write data.
REQ-010 SHALL have port d_out  output  DW  registered read data.
REQ-011 SHALL have port valid  output  1  one-cycle pulse marking new d_out.
REQ-012 SHALL have port busy  output  1  high while the clear sweep runs.

Function
REQ-013 FSM SHALL have two states: CLEAR and RUN.
REQ-014 In CLEAR, the block SHALL write 0 to address clr_ptr each cycle, starting at 0 and incrementing by 1.
REQ-015 CLEAR SHALL go to RUN in the cycle after clr_ptr = 2**AW-1 is written; the sweep SHALL take exactly 2**AW cycles.
REQ-016 busy SHALL be 1 in CLEAR and 0 in RUN.
REQ-017 In CLEAR, en, r and w SHALL be ignored, and valid SHALL stay 0.
REQ-018 In RUN, en=1 and w=1 SHALL write d_in to mem[add] at the clock edge, whatever the value of r.
REQ-019 A write SHALL NOT change d_out and SHALL leave valid=0.
REQ-020 In RUN, en=1, w=0 and r=1 SHALL load mem[add] into d_out at the edge and drive valid=1 for that one cycle (1-cycle latency).
REQ-021 Back-to-back reads SHALL give one valid pulse per cycle, with d_out following each address in order.
REQ-022 A read of an address written in the previous cycle SHALL return the new data.
REQ-023 en=0, or r=w=0, SHALL hold d_out and drive valid=0.
REQ-024 add SHALL be used modulo 2**AW; no out-of-range state exists.

Reset
REQ-025 When rst=1 at a rising edge: state = CLEAR, clr_ptr = 0, d_out = 0, valid = 0, busy = 1 from the next cycle.
REQ-026 rst asserted during CLEAR SHALL restart the sweep from address 0.
REQ-027 rst asserted during RUN SHALL drop any in-flight access and start a full clear; memory contents SHALL read as 0 after busy falls.
REQ-028 rst SHALL take priority over every other input.

Configuration
REQ-029 With macro RAM_SYNC_CLR_PARITY_EN defined:
- each word SHALL store an extra even-parity bit computed from d_in on write (0 on clear);
- the block SHALL add port par_err  output  1;
- par_err SHALL pulse together with valid when the stored parity does not match the parity recomputed from the read data;
- par_err SHALL reset to 0.
REQ-030 Without RAM_SYNC_CLR_PARITY_EN:
- no parity storage SHALL exist;
- port par_err SHALL be absent;
- all other behaviour SHALL be identical.

Verification
REQ-031 Clear sweep: rst=1 for 1 cycle -> busy=1 for exactly 16384 cycles, then 0; read of add=2, 2050 and 16383 -> d_out=0, valid=1.
REQ-032 Write/read sweep: write d_in=i to add=i for i=2,2050,...,14338 with r=w=en=1, then read the same addresses with w=0 -> d_out=i one cycle after each read, valid=1 each cycle.
REQ-033 Access during clear: during busy=1, apply en=1, w=1, add=5, d_in=16'hABCD; after busy falls, read add=5 -> d_out=0.
REQ-034 Hold behaviour: after reading 16'h1234 from add=7, set en=0 for 3 cycles -> d_out stays 16'h1234 and valid=0; with en=1 and r=w=0 -> same result.
REQ-035 Reset mid-operation: rst at clr_ptr=100 -> sweep restarts, busy lasts another 16384 cycles; rst in RUN after writing add=9 -> add=9 later reads 0.
REQ-036 Parity (RAM_SYNC_CLR_PARITY_EN defined): write 16'h0001 to add=3, force the stored parity bit to the wrong value, read -> valid=1 and par_err=1; a clean read -> par_err=0.

Source files
------------

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM that zero-fills itself after every reset, then serves reads and writes.
// Optional feature: define RAM_SYNC_CLR_PARITY_EN to store an even-parity bit per word and flag mismatches on par_err.
module ram_sync_clr #(
  parameter int DW = 16,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          w,
  input  logic          r,
  input  logic [AW-1:0] add,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  output logic          valid,
  output logic          busy
`ifdef RAM_SYNC_CLR_PARITY_EN
  ,
  output logic          par_err
`endif
);

  localparam int DEPTH = 1 << AW;
`ifdef RAM_SYNC_CLR_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state_reg;
  logic [AW-1:0] clr_ptr_reg;
  logic [MW-1:0] mem [DEPTH];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_word;
  logic          rd_en;

  assign busy = (state_reg == ST_CLEAR);

  // One shared write port: the clear sweep owns it while busy, the user port afterwards.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = add;
    wr_word = '0;
    rd_en   = 1'b0;
    if (!rst) begin
      if (state_reg == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_reg;
      end else if (en) begin
        if (w) begin
          wr_en = 1'b1;
`ifdef RAM_SYNC_CLR_PARITY_EN
          wr_word = {^d_in, d_in};
`else
          wr_word = d_in;
`endif
        end else if (r) begin
          rd_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_ptr_reg <= '0;
    end else if (state_reg == ST_CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + 1'b1;
      if (clr_ptr_reg == {AW{1'b1}}) begin
        state_reg <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read port; d_out holds its last value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
      valid <= 1'b0;
    end else begin
      valid <= rd_en;
      if (rd_en) begin
        d_out <= mem[add][DW-1:0];
      end
    end
  end

`ifdef RAM_SYNC_CLR_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= rd_en && (mem[add][DW] != ^mem[add][DW-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed self-checking bench for ram_sync_clr: clear sweep, writes/reads, hold, reset during clear and run.
// Define RAM_SYNC_CLR_PARITY_EN for both files to exercise the parity option.
module tb_ram_sync_clr;

  localparam int DW = 16;
  localparam int AW = 14;
  localparam int SWEEP = 1 << AW;

  logic          clk;
  logic          rst;
  logic          en;
  logic          w;
  logic          r;
  logic [AW-1:0] add;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          valid;
  logic          busy;
`ifdef RAM_SYNC_CLR_PARITY_EN
  logic          par_err;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  int bad_valid;
  logic [DW-1:0] exp_dout;

  ram_sync_clr #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .w     (w),
    .r     (r),
    .add   (add),
    .d_in  (d_in),
    .d_out (d_out),
    .valid (valid),
    .busy  (busy)
`ifdef RAM_SYNC_CLR_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    en = 1'b0; w = 1'b0; r = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] dv, input logic rv);
    en = 1'b1; w = 1'b1; r = rv; add = a; d_in = dv;
    tick();
    $display("write add=%0d data=%0h", a, dv);
    check("write_valid", {31'd0, valid}, 32'd0);
    check("write_dout_hold", {16'd0, d_out}, {16'd0, exp_dout});
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expv);
    en = 1'b1; w = 1'b0; r = 1'b1; add = a;
    tick();
    $display("read  add=%0d data=%0h valid=%0b", a, d_out, valid);
    check("read_dout", {16'd0, d_out}, {16'd0, expv});
    check("read_valid", {31'd0, valid}, 32'd1);
    exp_dout = expv;
  endtask

  // Counts busy cycles after the reset edge, with a write attempt held on the inputs throughout.
  task automatic measure_sweep(input string tag);
    n = 0;
    bad_valid = 0;
    while (busy === 1'b1 && n < SWEEP + 100) begin
      if (valid !== 1'b0) bad_valid++;
      tick();
      n++;
    end
    idle();
    $display("sweep %s busy_cycles=%0d", tag, n);
    check({tag, "_len"}, n, SWEEP);
    check({tag, "_valid_low"}, bad_valid, 0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; add = '0; d_in = '0; exp_dout = '0;
    idle();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_dout", {16'd0, d_out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;

    // Access attempt during the sweep; it must be ignored.
    en = 1'b1; w = 1'b1; r = 1'b1; add = 14'd5; d_in = 16'hABCD;
    for (int i = 0; i < 100; i++) tick();
    check("clr_busy_ptr100", {31'd0, busy}, 32'd1);
    check("clr_valid", {31'd0, valid}, 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    measure_sweep("sweep_restart");

    do_read(14'd5, 16'h0000);
    do_read(14'd2, 16'h0000);
    do_read(14'd2050, 16'h0000);
    do_read(14'd16383, 16'h0000);

    for (int i = 2; i <= 14338; i += 2048) do_write(i[AW-1:0], i[DW-1:0], 1'b1);
    for (int i = 2; i <= 14338; i += 2048) do_read(i[AW-1:0], i[DW-1:0]);

    // Read immediately after write, then hold behaviour.
    do_write(14'd7, 16'h1234, 1'b0);
    do_read(14'd7, 16'h1234);
    en = 1'b0; w = 1'b1; r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_en0_dout", {16'd0, d_out}, 32'h1234);
      check("hold_en0_valid", {31'd0, valid}, 32'd0);
    end
    en = 1'b1; w = 1'b0; r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_idle_dout", {16'd0, d_out}, 32'h1234);
      check("hold_idle_valid", {31'd0, valid}, 32'd0);
    end

`ifdef RAM_SYNC_CLR_PARITY_EN
    do_write(14'd3, 16'h0001, 1'b0);
    do_read(14'd3, 16'h0001);
    check("par_clean", {31'd0, par_err}, 32'd0);
    dut.mem[3][DW] = ~dut.mem[3][DW];
    do_read(14'd3, 16'h0001);
    check("par_bad", {31'd0, par_err}, 32'd1);
    do_read(14'd7, 16'h1234);
    check("par_clean2", {31'd0, par_err}, 32'd0);
`endif

    do_write(14'd9, 16'h5A5A, 1'b0);
    do_read(14'd9, 16'h5A5A);
    // Reset in RUN with a read pending on the inputs.
    rst = 1'b1; en = 1'b1; w = 1'b0; r = 1'b1; add = 14'd9;
    tick();
    rst = 1'b0;
    exp_dout = '0;
    check("run_rst_dout", {16'd0, d_out}, 32'd0);
    check("run_rst_valid", {31'd0, valid}, 32'd0);
    check("run_rst_busy", {31'd0, busy}, 32'd1);
    en = 1'b1; w = 1'b1; r = 1'b0; add = 14'd5; d_in = 16'hABCD;
    measure_sweep("sweep_run_rst");
    do_read(14'd9, 16'h0000);
    do_read(14'd7, 16'h0000);
    do_read(14'd5, 16'h0000);

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
